serial_work_sender: RTL
=======================

# serial_work_sender

Host-side counterpart of the miner's serial link. Accepts one 512-bit work unit ({midstate, data2}) over a valid/ready handshake and transmits it as 64 bytes of 8N1 UART on `TxD`. Listens on `RxD` for 4-byte golden-nonce replies and presents each one as a 32-bit word with a one-cycle strobe. Used in bring-up harnesses and in hub FPGAs that feed one or more miner boards.

## Interface
- `CLKS_PER_BIT`, 434: clock cycles per UART bit; must be ≥ 4. Default is 50 MHz / 115200.
- `TIMEOUT_CLKS`, 43400: idle cycles after a received byte before a partial nonce is discarded.
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `work_valid`  in  1  `work` holds a unit to send.
- `work`  in  512  [511:256] midstate, [255:0] data2.
- `work_ready`  out  1  high when idle and able to accept work.
- `TxD`  out  1  UART transmit line, idle high.
- `RxD`  in  1  UART receive line, asynchronous.
- `nonce`  out  32  last assembled golden nonce.
- `nonce_valid`  out  1  one-cycle strobe when `nonce` updates.
- `frame_err`  out  1  one-cycle strobe when a received stop bit is sampled low.
- `busy`  out  1  equals !`work_ready`.

## Operation
- **Reset values:** `TxD`=1, `work_ready`=1, `busy`=0, `nonce`=0, `nonce_valid`=0, `frame_err`=0. Both state machines return to IDLE and all counters clear.
- **Reset mid-frame:** `TxD` returns high on the next cycle. Any partial nonce is lost.
- **TX FSM states:** IDLE, START, DATA, STOP.
  - IDLE → START when `work_valid && work_ready`. The 512-bit word is latched and byte index set to 0.
  - START drives 0 for one bit time. DATA sends 8 bits, LSB first. STOP drives 1 for one bit time.
  - From STOP: → START with index+1 if index<63; → IDLE if index==63.
- **TX byte order:** byte k = `work[511-8k -: 8]`, i.e. midstate MSB byte first, data2 LSB byte last.
- **TX back-to-back:** no idle gap between bytes.
- **`work_valid` while busy:** ignored. No queueing.
- `work` changing after acceptance has no effect.
- **RX input:** `RxD` passes through a 2-flop synchronizer.
- **RX FSM states:** IDLE, START, DATA, STOP.
  - IDLE → START on the synchronized falling edge.
  - START samples at CLKS_PER_BIT/2 (integer division). If the line is high there, it is a glitch → IDLE.
  - DATA samples 8 bits at CLKS_PER_BIT spacing, LSB first.
  - STOP samples once more. High: byte accepted. Low: `frame_err` pulse, byte discarded, nonce byte count cleared. Either way → IDLE immediately after the stop sample.
- **Nonce assembly:** first received byte → `nonce[7:0]`, fourth → `nonce[31:24]`. Bytes build in a shadow register; `nonce` updates only when the 4th byte completes.
- **Timeout:** a counter runs while the byte count is 1–3 and RX is IDLE. It resets on each accepted byte. Reaching TIMEOUT_CLKS clears the byte count; the partial nonce is discarded, no strobe.
- TX and RX are fully independent, so simultaneous send and receive is legal.

## Timing
- Acceptance cycle T (`work_valid && work_ready` high at edge T):
  - `work_ready` low from T+1.
  - `TxD` falls at T+1.
  - Each bit lasts exactly CLKS_PER_BIT cycles.
- Full transfer: 640·CLKS_PER_BIT cycles. `TxD` is high for the final bit time (byte 63 stop bit). `work_ready` rises at T+1+640·CLKS_PER_BIT.
- The earliest next acceptance is on that same cycle. The next start bit then follows with no extra gap.
- RX sample for bit n (start=0, data 1..8, stop=9) occurs (CLKS_PER_BIT/2 + n·CLKS_PER_BIT) cycles after the synchronized falling edge. Add 2 cycles of synchronizer latency relative to raw `RxD`.
- `nonce_valid` / `frame_err` assert the cycle after the stop-bit sample, for exactly one cycle.
- Timeout boundary: the byte count clears when the counter equals TIMEOUT_CLKS. A start edge arriving on that same cycle begins a new byte 0.

## Test plan
- **Idle reset:** with CLKS_PER_BIT=4, assert `reset` 2 cycles → `TxD`=1, `work_ready`=1, no strobes for 100 cycles.
- **Single work unit:** `work`={256'h2b3f…c0b5, 256'h…39f3001b6b7b8d4dc14bfc31} → UART monitor decodes 64 bytes. First byte 8'h2b, last byte 8'h31. `work_ready` low for exactly 2560 cycles; second `work_valid` during transfer is ignored.
- **Back-to-back:** `work_valid` held high with two units → second start bit begins on the cycle `work_ready` rises. No idle bit between units.
- **Nonce receive:** drive bytes 0xDC, 0xBF, 0xD0, 0x01 on `RxD` → one `nonce_valid` with `nonce`=32'h01D0BFDC.
- **Framing error:** stop bit low on byte 2 → `frame_err` pulse, no `nonce_valid`. A following clean 4-byte burst yields the correct nonce.
- **Timeout and reset:** with TIMEOUT_CLKS=100, send 2 bytes, wait 150 cycles, send 4 bytes → exactly one nonce from the last 4. Then assert `reset` mid-TX byte 10 → `TxD`=1 next cycle, `work_ready`=1.

Source files
------------

// File: rtl/serial_work_sender.sv
// Host-side serial link: sends 512-bit work units as 64 UART bytes
// and assembles 4-byte golden-nonce replies received on RxD.
module serial_work_sender #(
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_CLKS = 43400
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         work_valid,
    input  logic [511:0] work,
    output logic         work_ready,
    output logic         TxD,
    input  logic         RxD,
    output logic [31:0]  nonce,
    output logic         nonce_valid,
    output logic         frame_err,
    output logic         busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TMO_END  = TW'(TIMEOUT_CLKS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    state_e          tx_state_q, tx_state_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [2:0]      tx_bit_q, tx_bit_d;
    logic [5:0]      tx_idx_q, tx_idx_d;
    logic [511:0]    tx_sr_q, tx_sr_d;
    logic            txd_q, txd_d;
    logic            ready_q, ready_d;
    logic [7:0]      tx_byte;

    state_e          rx_state_q, rx_state_d;
    logic            rx_s1_q, rx_s2_q, rx_prev_q;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_byte_q, rx_byte_d;
    logic [1:0]      rx_num_q, rx_num_d;
    logic [23:0]     shadow_q, shadow_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [31:0]     nonce_q, nonce_d;
    logic            nv_q, nv_d;
    logic            fe_q, fe_d;
    logic            rx_fall;

    // The byte on the wire is always the top byte of the shift register
    assign tx_byte = tx_sr_q[511:504];

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_idx_d   = tx_idx_q;
        tx_sr_d    = tx_sr_q;
        txd_d      = txd_q;
        ready_d    = ready_q;
        unique case (tx_state_q)
            S_IDLE: begin
                if (work_valid) begin
                    tx_state_d = S_START;
                    tx_sr_d    = work;
                    tx_idx_d   = 6'd0;
                    tx_cnt_d   = '0;
                    txd_d      = 1'b0;
                    ready_d    = 1'b0;
                end
            end
            S_START: begin
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d   = '0;
                    tx_state_d = S_DATA;
                    tx_bit_d   = 3'd0;
                    txd_d      = tx_byte[0];
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = S_STOP;
                        txd_d      = 1'b1;
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                        txd_d    = tx_byte[tx_bit_q + 3'd1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d = '0;
                    if (tx_idx_q == 6'd63) begin
                        tx_state_d = S_IDLE;
                        ready_d    = 1'b1;
                    end else begin
                        tx_idx_d   = tx_idx_q + 6'd1;
                        tx_sr_d    = {tx_sr_q[503:0], 8'h00};
                        tx_state_d = S_START;
                        txd_d      = 1'b0;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
    end

    assign rx_fall = rx_prev_q & ~rx_s2_q;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_byte_d  = rx_byte_q;
        rx_num_d   = rx_num_q;
        shadow_d   = shadow_q;
        tmo_d      = tmo_q;
        nonce_d    = nonce_q;
        nv_d       = 1'b0;
        fe_d       = 1'b0;
        unique case (rx_state_q)
            S_IDLE: begin
                if (rx_fall) begin
                    rx_state_d = S_START;
                    rx_cnt_d   = '0;
                end
                // A partial nonce left idle too long is dropped
                if (rx_num_q != 2'd0) begin
                    if (tmo_q == TMO_END) begin
                        rx_num_d = 2'd0;
                        tmo_d    = '0;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end else begin
                    tmo_d = '0;
                end
            end
            S_START: begin
                if (rx_cnt_q == HALF_END) begin
                    rx_cnt_d = '0;
                    if (rx_s2_q) begin
                        rx_state_d = S_IDLE;
                    end else begin
                        rx_state_d = S_DATA;
                        rx_bit_d   = 3'd0;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (rx_cnt_q == BIT_END) begin
                    rx_cnt_d  = '0;
                    rx_byte_d = {rx_s2_q, rx_byte_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = S_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (rx_cnt_q == BIT_END) begin
                    rx_cnt_d   = '0;
                    rx_state_d = S_IDLE;
                    tmo_d      = '0;
                    if (rx_s2_q) begin
                        unique case (rx_num_q)
                            2'd0: shadow_d[7:0]   = rx_byte_q;
                            2'd1: shadow_d[15:8]  = rx_byte_q;
                            2'd2: shadow_d[23:16] = rx_byte_q;
                            2'd3: begin
                                nonce_d = {rx_byte_q, shadow_q};
                                nv_d    = 1'b1;
                            end
                        endcase
                        rx_num_d = rx_num_q + 2'd1;
                    end else begin
                        fe_d     = 1'b1;
                        rx_num_d = 2'd0;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_idx_q   <= '0;
            tx_sr_q    <= '0;
            txd_q      <= 1'b1;
            ready_q    <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_byte_q  <= '0;
            rx_num_q   <= '0;
            shadow_q   <= '0;
            tmo_q      <= '0;
            nonce_q    <= '0;
            nv_q       <= 1'b0;
            fe_q       <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_idx_q   <= tx_idx_d;
            tx_sr_q    <= tx_sr_d;
            txd_q      <= txd_d;
            ready_q    <= ready_d;
            rx_state_q <= rx_state_d;
            rx_s1_q    <= RxD;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_byte_q  <= rx_byte_d;
            rx_num_q   <= rx_num_d;
            shadow_q   <= shadow_d;
            tmo_q      <= tmo_d;
            nonce_q    <= nonce_d;
            nv_q       <= nv_d;
            fe_q       <= fe_d;
        end
    end

    assign work_ready  = ready_q;
    assign busy        = ~ready_q;
    assign TxD         = txd_q;
    assign nonce       = nonce_q;
    assign nonce_valid = nv_q;
    assign frame_err   = fe_q;

endmodule
